// File: rtl/jtsdram_pkg.sv
// jtsdram_pkg: shared FSM encoding, gap width and address bit-reversal for the jtsdram tester.
package jtsdram_pkg;
  localparam int GAPW = 4;
  typedef enum logic [2:0] {IDLE, GAP, REQ, WAIT, DONE} state_t;
  // Reverses the low w bits of x (w <= 32); bits above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = {<<{x}};
    return r >> (32 - w);
  endfunction
endpackage

// File: rtl/jtsdram_rnd.sv
// jtsdram_rnd: free-running 16-bit maximal LFSR; ports clk, rst, adv (advance), q (low OW bits of the state).
module jtsdram_rnd #(
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [OW-1:0] q
);
  logic [15:0] r;
  always_ff @(posedge clk)
    if (rst) r <= 16'hace1;
    else if (adv) r <= {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
  assign q = r[OW-1:0];
endmodule

// File: rtl/jtsdram_bank_chk.sv
// jtsdram_bank_chk: walks a 2^AW-word SDRAM region over rd/ack/rdy, compares din with data_ref, reports bad/err_cnt/first_*/tout; start restarts, rnd picks bit-reversed order, slow/LVBL gate reads.
module jtsdram_bank_chk
  import jtsdram_pkg::*;
#(
  parameter int AW   = 22,
  parameter int DW   = 16,
  parameter int ERRW = 8,
  parameter int TOW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            rnd,
  input  logic            slow,
  input  logic            LVBL,
  output logic [AW-1:0]   sdram_addr,
  output logic            rd,
  input  logic            ack,
  input  logic            rdy,
  input  logic [DW-1:0]   din,
  input  logic [DW-1:0]   data_ref,
  output logic            busy,
  output logic            done,
  output logic            bad,
  output logic [ERRW-1:0] err_cnt,
  output logic [AW-1:0]   first_addr,
  output logic [DW-1:0]   first_data,
  output logic            tout
);
  state_t          st;
  logic [AW-1:0]   cnt;
  logic            rnd_l;
  logic [GAPW-1:0] gap;
  logic [GAPW-1:0] lfsr;
  logic [TOW-1:0]  wd;
  logic            gate, to, err, fin;
  jtsdram_rnd #(.OW(GAPW)) u_rnd (.clk(clk), .rst(rst), .adv(1'b1), .q(lfsr));
  // rdy wins over a watchdog that saturates in the same cycle
  always_comb begin
    gate = slow ? gap == '0 : LVBL;
    to   = !rdy && &wd;
    fin  = st == WAIT && (rdy || &wd);
    err  = st == WAIT && (to || (rdy && din !== data_ref));
  end
  always_ff @(posedge clk)
    if (rst) begin
      st         <= IDLE;
      cnt        <= '0;
      rnd_l      <= 1'b0;
      gap        <= '0;
      wd         <= '0;
      rd         <= 1'b0;
      sdram_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bad        <= 1'b0;
      tout       <= 1'b0;
      err_cnt    <= '0;
      first_addr <= '0;
      first_data <= '0;
    end else if (start) begin
      st         <= GAP;
      cnt        <= '0;
      rnd_l      <= rnd;
      gap        <= lfsr;
      rd         <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      bad        <= 1'b0;
      tout       <= 1'b0;
      err_cnt    <= '0;
      first_addr <= '0;
      first_data <= '0;
    end else begin
      if (err) begin
        bad     <= 1'b1;
        tout    <= tout | to;
        err_cnt <= err_cnt + ERRW'(!(&err_cnt));
        if (!bad) begin
          first_addr <= sdram_addr;
          first_data <= to ? '0 : din;
        end
      end
      case (st)
        GAP:
          if (gate) begin
            st         <= REQ;
            rd         <= 1'b1;
            sdram_addr <= rnd_l ? AW'(bitrev(32'(cnt), AW)) : cnt;
          end else if (gap != '0) gap <= gap - 1'b1;
        REQ:
          if (ack) begin
            st <= WAIT;
            rd <= 1'b0;
            wd <= '0;
          end
        WAIT:
          if (!fin) wd <= wd + 1'b1;
          else if (&cnt) begin
            st   <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            st  <= GAP;
            cnt <= cnt + 1'b1;
            gap <= lfsr;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// tb_jtsdram_bank_chk: randomized bench with a behavioural SDRAM/controller model and pass-level expectations.
module tb_jtsdram_bank_chk;
  localparam int AW = 4, DW = 16, ERRW = 2, TOW = 4, N = 16;
  logic clk = 0, rst = 1, start = 0, rnd = 0, slow = 0, LVBL = 1, ack = 0, rdy = 0;
  logic [DW-1:0] din = '0, data_ref = '0;
  logic [AW-1:0] sdram_addr, first_addr;
  logic rd, busy, done, bad, tout;
  logic [ERRW-1:0] err_cnt;
  logic [DW-1:0] first_data;
  int checks = 0, errors = 0;
  bit corrupt[N], noresp[N], visited[N];
  int order[N];
  bit m_rnd = 0;
  int idx = 0, lat_fix = 0, t_rdy = -1, cyc = 0;
  bit [15:0] gap_seen = '0;

  always #5 clk = ~clk;

  jtsdram_bank_chk #(.AW(AW), .DW(DW), .ERRW(ERRW), .TOW(TOW)) dut (
    .clk(clk), .rst(rst), .start(start), .rnd(rnd), .slow(slow), .LVBL(LVBL),
    .sdram_addr(sdram_addr), .rd(rd), .ack(ack), .rdy(rdy), .din(din), .data_ref(data_ref),
    .busy(busy), .done(done), .bad(bad), .err_cnt(err_cnt), .first_addr(first_addr),
    .first_data(first_data), .tout(tout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_addr(input int i);
    int r = 0;
    if (!m_rnd) return i;
    for (int b = 0; b < AW; b++) if ((i >> b) & 1) r += 1 << (AW - 1 - b);
    return r;
  endfunction

  // Controller + memory model; checks the request address on every cycle rd is high.
  initial begin
    int wcnt = 0, lat = 0, gap;
    bit pend = 0, rd_prev = 0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pdin = '0;
    forever begin
      @(negedge clk);
      cyc++;
      ack = 0;
      rdy = 0;
      din = DW'($urandom);
      data_ref = DW'($urandom);
      if (rd) chk("req_addr", sdram_addr, idx < N ? exp_addr(idx) : -1);
      if (rd && !rd_prev && t_rdy >= 0) begin
        gap = cyc - t_rdy - 2;
        if (!slow && LVBL) chk("gap_fast", gap, 0);
        if (slow) begin
          chk("gap_range", gap inside {[0:15]}, 1);
          if (gap inside {[0:15]}) gap_seen[gap] = 1;
        end
      end
      rd_prev = rd;
      if (pend) begin
        lat--;
        if (lat == 0) begin
          rdy = 1;
          din = pdin;
          data_ref = 16'(paddr) * 16'd3;
          pend = 0;
          t_rdy = cyc;
        end
      end else if (rd) begin
        if (wcnt == 0) begin
          ack = 1;
          paddr = sdram_addr;
          if (idx < N) order[idx] = int'(paddr);
          idx++;
          visited[paddr] = 1;
          pdin = corrupt[paddr] ? 16'hdead : 16'(paddr) * 16'd3;
          pend = !noresp[paddr];
          lat = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 5));
          wcnt = lat_fix != 0 ? 0 : int'($urandom_range(0, 3));
          t_rdy = -1;
        end else wcnt--;
      end
    end
  end

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      corrupt[i] = 0;
      noresp[i] = 0;
    end
  endtask

  task automatic begin_pass(input bit r);
    start = 1;
    rnd = r;
    m_rnd = r;
    idx = 0;
    t_rdy = -1;
    for (int i = 0; i < N; i++) visited[i] = 0;
  endtask

  task automatic pulse_start(input bit r);
    @(negedge clk);
    begin_pass(r);
    @(negedge clk);
    start = 0;
    rnd = ~r;
  endtask

  task automatic finish_pass(input string name);
    int n = 0, fa = 0, nv = 0;
    logic [DW-1:0] fd = '0;
    bit to = 0;
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    chk({name, "_done"}, done, 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      int a = exp_addr(i);
      if (corrupt[a] || noresp[a]) begin
        if (n == 0) begin
          fa = a;
          fd = noresp[a] ? '0 : 16'hdead;
        end
        n++;
        to |= noresp[a];
      end
      nv += visited[i];
    end
    chk({name, "_done_held"}, done, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_reads"}, idx, N);
    chk({name, "_visited"}, nv, N);
    chk({name, "_bad"}, bad, n > 0);
    chk({name, "_tout"}, tout, to);
    chk({name, "_err_cnt"}, err_cnt, n > 3 ? 3 : n);
    chk({name, "_first_addr"}, first_addr, fa);
    chk({name, "_first_data"}, first_data, fd);
  endtask

  initial begin
    bit gated_ok;
    clear_faults();
    repeat (3) @(negedge clk);
    chk("rst_rd", rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_bad", bad, 0);
    chk("rst_tout", tout, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_addr", first_addr, 0);
    chk("rst_first_data", first_data, 0);
    chk("rst_sdram_addr", sdram_addr, 0);

    lat_fix = 3;
    pulse_start(0);
    chk("start_busy_t1", busy, 1);
    chk("start_rd_t1", rd, 0);
    @(negedge clk);
    chk("start_rd_t2", rd, 1);
    finish_pass("linear");
    chk("linear_order0", order[0], 0);
    chk("linear_order15", order[15], 15);

    lat_fix = 0;
    pulse_start(1);
    finish_pass("bitrev");
    chk("bitrev_order1", order[1], 8);
    chk("bitrev_order2", order[2], 4);
    chk("bitrev_order3", order[3], 12);
    chk("bitrev_order4", order[4], 2);
    chk("bitrev_order15", order[15], 15);

    corrupt[5] = 1;
    corrupt[9] = 1;
    pulse_start(0);
    finish_pass("mismatch");
    chk("mismatch_err_lit", err_cnt, 2);
    chk("mismatch_first_addr_lit", first_addr, 5);
    chk("mismatch_first_data_lit", first_data, 16'hdead);
    clear_faults();

    noresp[7] = 1;
    pulse_start(0);
    finish_pass("timeout");
    chk("timeout_tout_lit", tout, 1);
    chk("timeout_first_addr_lit", first_addr, 7);
    chk("timeout_first_data_lit", first_data, 0);
    clear_faults();

    LVBL = 0;
    pulse_start(0);
    gated_ok = 1;
    repeat (100) begin
      @(negedge clk);
      if (rd) gated_ok = 0;
    end
    chk("gated_rd_low", gated_ok, 1);
    LVBL = 1;
    finish_pass("gated");

    slow = 1;
    gap_seen = '0;
    pulse_start($urandom_range(0, 1));
    finish_pass("slow");
    chk("slow_gap_variety", $countones(gap_seen) >= 2, 1);
    slow = 0;

    corrupt[1] = 1; corrupt[3] = 1; corrupt[5] = 1; corrupt[9] = 1; corrupt[11] = 1;
    pulse_start(0);
    finish_pass("saturate");
    chk("saturate_err_lit", err_cnt, 3);
    clear_faults();

    corrupt[2] = 1;
    corrupt[6] = 1;
    lat_fix = 3;
    pulse_start(0);
    begin
      bit seen = 0;
      for (int i = 0; i < 1000 && !seen; i++) begin
        @(posedge clk);
        seen = ack && sdram_addr == 6;
      end
      chk("restart_reached_addr6", seen, 1);
    end
    @(negedge clk);
    chk("restart_pre_err", err_cnt, 1);
    begin_pass(0);
    @(negedge clk);
    start = 0;
    chk("restart_err_clear", err_cnt, 0);
    chk("restart_bad_clear", bad, 0);
    chk("restart_busy", busy, 1);
    chk("restart_rd_low", rd, 0);
    @(negedge clk);
    chk("restart_rd", rd, 1);
    chk("restart_addr0", sdram_addr, 0);
    finish_pass("restart");
    clear_faults();
    lat_fix = 0;

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < N; i++) begin
        corrupt[i] = $urandom_range(0, 7) == 0;
        noresp[i] = $urandom_range(0, 15) == 0;
      end
      slow = $urandom_range(0, 1);
      pulse_start($urandom_range(0, 1));
      finish_pass($sformatf("rand%0d", p));
      clear_faults();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtsdram_bank_chk.md
# jtsdram_bank_chk

Parametrised read-only SDRAM bank checker. Walks every address of a `2^AW`-word region and drives the SDRAM controller's request/ack/rdy handshake directly, with no cache in between. Each returned word is compared against an externally supplied reference word. The result is reported as a pass/fail flag, a saturating error count, first-failure capture and a per-read timeout watchdog. It sits between the test sequencer and one SDRAM bank port in the jtsdram tester and supersedes the fixed-width single-mode bank reader.

## Interface
Parameters:
- `AW`, 22: address width in words; region is `0 .. 2^AW-1`.
- `DW`, 16: data width; 16 or 32.
- `ERRW`, 8: width of the error counter.
- `TOW`, 8: width of the watchdog counter; timeout fires after `2^TOW-1` cycles.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: one-cycle pulse; (re)starts a pass from address 0.
- `rnd` in 1: address order, sampled at `start`. 0 = linear; 1 = bit-reversed counter.
- `slow` in 1: 1 = random gap between reads; 0 = reads gated by `LVBL`.
- `LVBL` in 1: active-high blanking gate, used when `slow` = 0.
- `sdram_addr` out AW: request address; stable while `rd` = 1.
- `rd` out 1: read request.
- `ack` in 1: controller accepted the request.
- `rdy` in 1: `din` valid.
- `din` in DW: read data.
- `data_ref` in DW: expected word for `sdram_addr`; valid in the `rdy` cycle.
- `busy` out 1: pass in progress.
- `done` out 1: pass finished; held until the next `start`.
- `bad` out 1: sticky; at least one mismatch or timeout.
- `err_cnt` out ERRW: saturating error count.
- `first_addr` out AW: address of the first error.
- `first_data` out DW: `din` at the first error (0 if that error was a timeout).
- `tout` out 1: sticky; at least one timeout.

## Operation
- FSM states: IDLE, GAP, REQ, WAIT, DONE.
- **IDLE:** on `start`:
  - clear `cnt`, `bad`, `tout`, `err_cnt`, `first_*`, `done`;
  - latch `rnd`;
  - go to GAP.
- **GAP:** leave for REQ when the gate is open.
  - `slow` = 0: gate open when `LVBL` = 1.
  - `slow` = 1: gate open when the gap counter reaches 0. The gap counter is loaded with `lfsr[3:0]` on every entry to GAP.
- **REQ:** `rd` = 1, `sdram_addr` = `rnd_l ? bitrev(cnt) : cnt`. On `ack`: `rd` = 0, go to WAIT, clear the watchdog.
- **WAIT:**
  - On `rdy`: compare `din` with `data_ref` using 4-state `!==`. A mismatch is an error.
  - If the watchdog saturates without `rdy`, that is an error and also sets `tout`.
  - Either way, leave WAIT.
- **On an error:**
  - set `bad`;
  - `err_cnt` += 1, saturating at all-ones;
  - if this is the first error of the pass, capture `first_addr`/`first_data`.
- **Leaving WAIT:** if `cnt` is all-ones, go to DONE. Otherwise `cnt` += 1 and go to GAP.
- **DONE:** `done` = 1, `busy` = 0. Stay until `start`.
- **`start` in any state:** aborts the pass and restarts it from address 0. `rd` drops the same cycle. A late `rdy` from the aborted read is ignored, because it arrives outside WAIT.
- **Simultaneous `ack` and `rdy` in REQ:** the `rdy` is not consumed. The controller guarantees `rdy` comes at least 1 cycle after `ack`.
- **`rdy` on the same cycle the watchdog saturates:** counted as a data compare, not a timeout.

## Timing
- Reset values:
  - `rd` = 0, `busy` = 0, `done` = 0, `bad` = 0, `tout` = 0;
  - `err_cnt` = 0, `first_addr` = 0, `first_data` = 0, `sdram_addr` = 0;
  - state = IDLE.
- `start` at cycle t: `busy` = 1 at t+1. With `slow` = 0 and `LVBL` = 1, `rd` = 1 at t+2.
- Back-to-back: from `rdy` at cycle t, the next `rd` is at t+2 (t+1 in GAP, open gate).
- Error flags update at the cycle after `rdy` or after the timeout.
- `done` rises the cycle after the final compare.
- All outputs are registered.
- Pass duration with `slow` = 0, `LVBL` = 1 and controller latency L: about `2^AW·(L+2)` cycles.

## Structure
- Package `jtsdram_pkg` holds:
  - the FSM state encoding;
  - the `bitrev` function;
  - the gap width constant `GAPW` = 4.
- Sub-module: reuse `jtsdram_rnd` for the 16-bit LFSR, with `adv` = 1 and its reset driven from `rst`.
- Everything else lives in a single module, about 200 lines.

## Test plan
- **Linear pass.** AW=4, DW=16, model returns `data_ref` = `din` = `addr*3`, latency 3, `slow` = 0, `LVBL` = 1 → 16 reads at addresses 0..15, then `done` = 1, `bad` = 0, `err_cnt` = 0.
- **Bit-reversed order.** `rnd` = 1, AW=4 → address sequence 0, 8, 4, 12, 2, …, 15; all 16 addresses visited exactly once.
- **Mismatch capture.** Model corrupts the word at addresses 5 and 9 (`din` = 16'hDEAD) → `bad` = 1, `err_cnt` = 2, `first_addr` = 5, `first_data` = 16'hDEAD.
- **Timeout.** TOW=4, model never asserts `rdy` for address 7 → `tout` = 1, `err_cnt` = 1, `first_addr` = 7, `first_data` = 0; the pass still completes.
- **Gating and slow gaps.** `slow` = 0, `LVBL` = 0 for 100 cycles → `rd` stays low, then resumes when `LVBL` = 1. Separately, `slow` = 1 → inter-read gaps of 0..15 cycles that match the LFSR.
- **Saturation and mid-pass restart.** ERRW=2 with 5 corrupted words → `err_cnt` = 3. Then `start` pulsed while in WAIT at address 6 → counters clear, the next `rd` is at address 0, and the stale `rdy` is ignored.
